// File: rtl/gouram_trace_buffer_ctrl_pkg.sv
// Shared types for the gouram trace path: trace record format and the
// trace buffer controller state encoding.
package gouram_datatypes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ticks;
  } trace_format;

  typedef enum logic [1:0] {
    BUF_IDLE   = 2'd0,
    BUF_ARMED  = 2'd1,
    BUF_FROZEN = 2'd2,
    BUF_DRAIN  = 2'd3
  } trace_buf_state_e;

endpackage

// File: rtl/gouram_trace_buffer_ctrl_ram.sv
// trace_buffer_ram: single-port synchronous RAM, one-cycle read latency.
// The array is not reset; the read register only updates on a read.
module trace_buffer_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single port: either write the addressed entry or register its contents.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/gouram_trace_buffer_ctrl.sv
// gouram_trace_buffer_ctrl: captures gouram trace records into a circular
// buffer, freezes on software stop or lock rise, and drains oldest-first
// through a valid/ready output.
// Configuration macro: GOURAM_TRACE_WRAP_EN (defined: overwrite oldest on a
// full buffer; undefined: drop the incoming record).
module gouram_trace_buffer_ctrl
  import gouram_datatypes::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned OVF_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trace_valid_i,
  input  trace_format                trace_data_i,
  input  logic                       trace_capture_enable_i,
  input  logic                       lock_i,
  input  logic signed [31:0]         counter_i,
  input  logic                       arm_i,
  input  logic                       stop_i,
  input  logic                       drain_i,
  output logic                       out_valid_o,
  output trace_format                out_data_o,
  input  logic                       out_ready_i,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [OVF_WIDTH-1:0]       overflow_o,
  output logic signed [31:0]         frozen_at_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = $bits(trace_format);

  trace_buf_state_e state, state_next;

  logic [AW-1:0]        wr_ptr, rd_ptr, ram_addr;
  logic [CW-1:0]        count;
  logic [OVF_WIDTH-1:0] overflow;
  logic signed [31:0]   frozen_at;
  logic                 lock_q;
  logic                 out_valid;
  logic [DW-1:0]        ram_rdata;

  logic lock_rise, full, capture, ram_we, rd_issue, freeze, handshake, ram_en;

  // Event decode shared by the FSM and the datapath.
  always_comb begin
    lock_rise = lock_i & ~lock_q;
    full      = (count == CW'(DEPTH));
    capture   = (state == BUF_ARMED) && trace_valid_i && trace_capture_enable_i;
`ifdef GOURAM_TRACE_WRAP_EN
    ram_we    = capture;
`else
    ram_we    = capture && !full;
`endif
    freeze    = (state == BUF_ARMED) && (stop_i || lock_rise);
    rd_issue  = (state == BUF_DRAIN) && !out_valid && (count != '0);
    handshake = out_valid && out_ready_i;
    ram_en    = ram_we || rd_issue;
    ram_addr  = ram_we ? wr_ptr : rd_ptr;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BUF_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; pulses outside their owning state are ignored.
  always_comb begin
    state_next = state;
    case (state)
      BUF_IDLE:   if (arm_i)   state_next = BUF_ARMED;
      BUF_ARMED:  if (freeze)  state_next = BUF_FROZEN;
      BUF_FROZEN: if (drain_i) state_next = BUF_DRAIN;
      BUF_DRAIN:  if (count == '0 && !out_valid) state_next = BUF_IDLE;
      default:    state_next = BUF_IDLE;
    endcase
  end

  // Pointers, occupancy, overflow, freeze stamp, lock edge and drain valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= '0;
      frozen_at <= '0;
      lock_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      lock_q <= lock_i;

      if (state == BUF_IDLE && arm_i) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= '0;
      end

      if (capture) begin
        if (full) begin
          if (overflow != '1) overflow <= overflow + OVF_WIDTH'(1);
`ifdef GOURAM_TRACE_WRAP_EN
          // Oldest entry is overwritten, so the read side advances with it.
          wr_ptr <= wr_ptr + AW'(1);
          rd_ptr <= rd_ptr + AW'(1);
`endif
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + CW'(1);
        end
      end

      if (freeze) frozen_at <= counter_i;

      // RAM output register carries the record, so valid rises with it.
      if (rd_issue) begin
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
        rd_ptr    <= rd_ptr + AW'(1);
        count     <= count - CW'(1);
      end
    end
  end

  // Writer (ARMED) and reader (DRAIN) must never contend for the port.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(ram_we && rd_issue));
  end

  trace_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (trace_data_i),
    .rdata (ram_rdata)
  );

  assign out_valid_o = out_valid;
  assign out_data_o  = out_valid ? trace_format'(ram_rdata) : '0;
  assign state_o     = state;
  assign count_o     = count;
  assign overflow_o  = overflow;
  assign frozen_at_o = frozen_at;

endmodule

// File: tb/tb_gouram_trace_buffer_ctrl.sv
// Directed bench for gouram_trace_buffer_ctrl (DEPTH=8). Overflow
// expectations follow GOURAM_TRACE_WRAP_EN.
module tb_gouram_trace_buffer_ctrl;
  import gouram_datatypes::*;

  localparam int unsigned DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               trace_valid_i;
  trace_format        trace_data_i;
  logic               trace_capture_enable_i;
  logic               lock_i;
  logic signed [31:0] counter_i;
  logic               arm_i, stop_i, drain_i;
  logic               out_valid_o;
  trace_format        out_data_o;
  logic               out_ready_i;
  logic [1:0]         state_o;
  logic [3:0]         count_o;
  logic [15:0]        overflow_o;
  logic signed [31:0] frozen_at_o;

  int tests = 0;
  int errors = 0;
  logic [63:0] got[$];
  int          stamp[$];

  gouram_trace_buffer_ctrl #(
    .DEPTH     (DEPTH),
    .OVF_WIDTH (16)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .trace_valid_i          (trace_valid_i),
    .trace_data_i           (trace_data_i),
    .trace_capture_enable_i (trace_capture_enable_i),
    .lock_i                 (lock_i),
    .counter_i              (counter_i),
    .arm_i                  (arm_i),
    .stop_i                 (stop_i),
    .drain_i                (drain_i),
    .out_valid_o            (out_valid_o),
    .out_data_o             (out_data_o),
    .out_ready_i            (out_ready_i),
    .state_o                (state_o),
    .count_o                (count_o),
    .overflow_o             (overflow_o),
    .frozen_at_o            (frozen_at_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] rec(input int i);
    logic [31:0] pc, tk;
    pc = 32'h1000_0000 + 32'(i);
    tk = 32'h0000_A000 + 32'(i);
    return {pc, tk};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm_i = 1'b1; tick(); arm_i = 1'b0;
  endtask

  task automatic do_stop(input int ctr);
    counter_i = ctr; stop_i = 1'b1; tick(); stop_i = 1'b0;
  endtask

  task automatic do_drain();
    drain_i = 1'b1; tick(); drain_i = 1'b0;
  endtask

  task automatic push(input int i);
    trace_valid_i = 1'b1; trace_data_i = rec(i); tick(); trace_valid_i = 1'b0;
  endtask

  // Collect every handshaken record until the controller returns to IDLE.
  task automatic drain_all();
    int cyc;
    cyc = 0;
    got.delete();
    stamp.delete();
    while (state_o != 2'd0 && cyc < 200) begin
      if (out_valid_o && out_ready_i) begin
        got.push_back(out_data_o);
        stamp.push_back(cyc);
      end
      tick();
      cyc++;
    end
    if (state_o != 2'd0) check("drain_timeout", state_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; trace_valid_i = 1'b0; trace_data_i = '0;
    trace_capture_enable_i = 1'b1; lock_i = 1'b0; counter_i = 0;
    arm_i = 1'b0; stop_i = 1'b0; drain_i = 1'b0; out_ready_i = 1'b1;
    tick(); tick();

    // Reset values
    check("rst_state", state_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_frozen", frozen_at_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    rst_n = 1'b1;
    tick();

    // Drain pulse in IDLE is ignored
    do_drain();
    check("idle_ignore_drain", state_o, 0);

    // Basic capture and drain: A..E
    do_arm();
    check("armed_state", state_o, 1);
    push(0);
    check("count_after_1", count_o, 1);
    for (int i = 1; i < 5; i++) push(i);
    check("count_after_5", count_o, 5);
    do_stop(55);
    check("stop_state", state_o, 2);
    check("stop_frozen", frozen_at_o, 55);
    do_drain();
    check("drain_state", state_o, 3);
    drain_all();
    check("basic_n", got.size(), 5);
    for (int k = 0; k < got.size() && k < 5; k++) check($sformatf("basic_rec%0d", k), got[k], rec(k));
    for (int k = 1; k < stamp.size(); k++) check($sformatf("basic_gap%0d", k), stamp[k] - stamp[k-1], 2);
    check("basic_count_end", count_o, 0);

    // Lock freeze; later valids not captured
    do_arm();
    for (int i = 16; i < 19; i++) push(i);
    counter_i = 100; lock_i = 1'b1; tick();
    check("lock_state", state_o, 2);
    check("lock_frozen", frozen_at_o, 100);
    push(19); push(20);
    check("lock_count_hold", count_o, 3);
    lock_i = 1'b0;
    do_drain();
    drain_all();
    check("lock_n", got.size(), 3);
    for (int k = 0; k < got.size() && k < 3; k++) check($sformatf("lock_rec%0d", k), got[k], rec(16 + k));

    // Overflow: 10 records into 8 entries
    do_arm();
    for (int i = 32; i < 42; i++) push(i);
    check("ovf_count", count_o, 8);
    check("ovf_overflow", overflow_o, 2);
    do_stop(7);
    do_drain();
    drain_all();
    check("ovf_n", got.size(), 8);
    for (int k = 0; k < got.size() && k < 8; k++) begin
`ifdef GOURAM_TRACE_WRAP_EN
      check($sformatf("ovf_rec%0d", k), got[k], rec(34 + k));
`else
      check($sformatf("ovf_rec%0d", k), got[k], rec(32 + k));
`endif
    end

    // Backpressure: hold ready low for 10 cycles with the first record shown
    do_arm();
    for (int i = 48; i < 53; i++) push(i);
    do_stop(9);
    out_ready_i = 1'b0;
    do_drain();
    tick();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_valid%0d", c), out_valid_o, 1);
      check($sformatf("bp_data%0d", c), out_data_o, rec(48));
      tick();
    end
    check("bp_count_hold", count_o, 5);
    out_ready_i = 1'b1;
    drain_all();
    check("bp_n", got.size(), 5);
    for (int k = 0; k < got.size() && k < 5; k++) check($sformatf("bp_rec%0d", k), got[k], rec(48 + k));

    // Write, lock rise and stop in the same cycle
    do_arm();
    push(64); push(65);
    trace_valid_i = 1'b1; trace_data_i = rec(66);
    counter_i = 77; lock_i = 1'b1; stop_i = 1'b1;
    tick();
    trace_valid_i = 1'b0; stop_i = 1'b0; lock_i = 1'b0;
    check("sim_count", count_o, 3);
    check("sim_state", state_o, 2);
    check("sim_frozen", frozen_at_o, 77);
    counter_i = 88; tick();
    lock_i = 1'b1; stop_i = 1'b1; tick();
    lock_i = 1'b0; stop_i = 1'b0;
    check("sim_frozen_once", frozen_at_o, 77);
    do_drain();
    drain_all();
    check("sim_n", got.size(), 3);
    if (got.size() == 3) check("sim_last", got[2], rec(66));

    // Reset mid-drain after two records, then re-arm
    do_arm();
    for (int i = 80; i < 85; i++) push(i);
    do_stop(3);
    do_drain();
    begin
      int taken, cyc;
      taken = 0; cyc = 0;
      while (taken < 2 && cyc < 50) begin
        if (out_valid_o) taken++;
        tick(); cyc++;
      end
      check("mid_taken", taken, 2);
    end
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mid_state", state_o, 0);
    check("mid_count", count_o, 0);
    check("mid_valid", out_valid_o, 0);
    do_arm();
    push(90); push(91);
    do_stop(4);
    do_drain();
    drain_all();
    check("rearm_n", got.size(), 2);
    for (int k = 0; k < got.size() && k < 2; k++) check($sformatf("rearm_rec%0d", k), got[k], rec(90 + k));

    // Drain of an empty buffer returns to IDLE the next cycle
    do_arm();
    do_stop(5);
    do_drain();
    check("empty_drain_state", state_o, 3);
    tick();
    check("empty_drain_idle", state_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/gouram_trace_buffer_ctrl.md
# gouram_trace_buffer_ctrl

Controller that captures the trace records produced by the gouram trace unit into a circular on-chip buffer. It sequences the buffer through arm, capture, freeze and drain phases, and shares the buffer's single memory port between the capture writer and a host-side drain reader. It sits between gouram's trace output (`trace_data_o`, `trace_capture_enable`, `lock`, `counter_o`) and the host or debug readout logic.

## Interface
- `DEPTH`, 256: number of buffer entries; must be a power of two and at least 2.
- `OVF_WIDTH`, 16: width of the overflow counter.
- `clk` in 1: clock; the design has one clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `trace_valid_i` in 1: `trace_data_i` holds a new record this cycle.
- `trace_data_i` in `$bits(trace_format)`: trace record from gouram.
- `trace_capture_enable_i` in 1: gouram's capture enable.
- `lock_i` in 1: gouram's lock flag; a rising edge freezes capture.
- `counter_i` in 32: gouram's cycle counter (signed).
- `arm_i` in 1: one-cycle pulse that starts capture.
- `stop_i` in 1: one-cycle pulse that freezes capture (software stop).
- `drain_i` in 1: one-cycle pulse that starts readout.
- `out_valid_o` out 1: drain record valid.
- `out_data_o` out `$bits(trace_format)`: drain record.
- `out_ready_i` in 1: the host accepts the record.
- `state_o` out 2: current controller state.
- `count_o` out `$clog2(DEPTH)+1`: number of records held in the buffer.
- `overflow_o` out `OVF_WIDTH`: overflow events, saturating.
- `frozen_at_o` out 32: value of `counter_i` latched when capture froze.

## Operation
- **States** (`state_o` encoding): IDLE=0, ARMED=1, FROZEN=2, DRAIN=3.
- **Transitions:**
  - IDLE→ARMED on `arm_i`. Entering ARMED clears `wr_ptr`, `rd_ptr`, `count_o` and `overflow_o`.
  - ARMED→FROZEN on `stop_i` or on a `lock_i` rising edge (`lock_i` high, previous value low).
  - FROZEN→DRAIN on `drain_i`.
  - DRAIN→IDLE when `count_o`=0 and no record is pending; a drain started with `count_o`=0 returns to IDLE the next cycle.
  - `arm_i`, `stop_i` and `drain_i` are ignored in every other state.
- **Capture:** in ARMED, a write occurs when `trace_valid_i && trace_capture_enable_i`. The write goes to `wr_ptr`, then `wr_ptr`++ (wraps mod `DEPTH`) and `count_o`++.
- **Full buffer** (`count_o`==`DEPTH`) with a write pending: behaviour depends on the `GOURAM_TRACE_WRAP_EN` configuration. `overflow_o` increments in both cases and saturates at all-ones.
- **Freeze:** on entering FROZEN, `frozen_at_o` latches `counter_i`.
- **Drain read sequence:**
  - In DRAIN, when `out_valid_o`=0, no read is in flight and `count_o`>0, issue a memory read at `rd_ptr`.
  - The data appears on `out_data_o` with `out_valid_o`=1 on the next cycle.
  - The record is held stable until `out_ready_i`=1.
  - On the handshake: `out_valid_o`←0, `rd_ptr`++ (wraps), `count_o`--.
- **Drain order:** oldest first. After a wrap, `rd_ptr` equals `wr_ptr` at freeze time.
- **Port sharing:** a read and a write never coincide, because the writer is active only in ARMED and the reader only in DRAIN. The single-port memory therefore needs no stall logic; an assertion checks this.
- **Simultaneous events:**
  - Write and freeze in the same cycle: the record is written, then the state goes to FROZEN.
  - `stop_i` and a `lock_i` rise together: a single freeze; `frozen_at_o` latches once.

## Timing
- Reset values: `state_o`=0, `count_o`=0, `overflow_o`=0, `frozen_at_o`=0, `out_valid_o`=0, `out_data_o`=0; internal `wr_ptr`=`rd_ptr`=0; previous-lock register=0.
- Reset applied mid-operation (any state, including mid-drain) returns to IDLE next cycle; `out_valid_o` drops, pending read discarded.
- Capture latency: record visible in `count_o` one cycle after the write cycle.
- State change: registered, one cycle after the triggering pulse.
- Drain throughput: one record per 2 cycles maximum (read issue, then present); a stall on `out_ready_i` holds data indefinitely.
- `count_o` width holds the value `DEPTH`; pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Configuration
- `GOURAM_TRACE_WRAP_EN` defined: on a full buffer, overwrite the oldest entry. `wr_ptr`++, `rd_ptr`++, `count_o` stays at `DEPTH`, `overflow_o`++. The buffer keeps the most recent `DEPTH` records.
- `GOURAM_TRACE_WRAP_EN` undefined: on a full buffer, drop the incoming record. Pointers and `count_o` are unchanged, `overflow_o`++. The buffer keeps the first `DEPTH` records.

## Structure
- `gouram_datatypes` gains the `trace_buf_state_e` enum (IDLE/ARMED/FROZEN/DRAIN). `trace_format` is reused from the existing package.
- Sub-module `trace_buffer_ram`: single-port synchronous RAM, `DEPTH` × `$bits(trace_format)`, 1-cycle read latency, write-enable, no reset on the array.
- The controller holds the FSM, pointers, counters, lock edge detector and drain output register.

## Test plan
- Basic capture and drain: reset, `arm_i`, 5 valid records A..E, `stop_i`, `drain_i`, `out_ready_i`=1 → out A,B,C,D,E in order, each 2 cycles apart, `count_o` 5→0, `state_o` returns to 0.
- Lock freeze: `counter_i`=100 at the `lock_i` rise → `state_o`=2 next cycle, `frozen_at_o`=100; later `trace_valid_i` pulses are not captured, `count_o` unchanged.
- Overflow, `DEPTH`=4, 6 records R0..R5:
  - with `GOURAM_TRACE_WRAP_EN` → drain R2..R5, `overflow_o`=2.
  - without the macro → drain R0..R3, `overflow_o`=2.
- Backpressure: hold `out_ready_i`=0 for 10 cycles mid-drain → `out_data_o` stable, `out_valid_o` high, no record lost or duplicated.
- Simultaneous valid and freeze: `trace_valid_i`, `lock_i` rise and `stop_i` in the same cycle → record captured, `count_o`+1, one freeze.
- Reset mid-drain after 2 of 5 records → IDLE, `count_o`=0, `out_valid_o`=0; re-arm works normally.
